// File: rtl/perceptron_pkg.sv
// Shared definitions for the perceptron trainer: FSM states, weight-load
// select encodings and the sign-binary weight rule.
package perceptron_pkg;

  typedef enum logic [3:0] {
    ST_INIT_B,
    ST_INIT_W0,
    ST_INIT_W1,
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_UPD_B,
    ST_UPD_W0,
    ST_UPD_W1
  } state_t;

  localparam logic [1:0] EN_NONE = 2'b00;
  localparam logic [1:0] EN_B    = 2'b01;
  localparam logic [1:0] EN_W0   = 2'b10;
  localparam logic [1:0] EN_W1   = 2'b11;

  // Weight points toward the sample for label 1 and away from it for label 0;
  // a clear sign bit (including zero) counts as non-negative.
  function automatic logic sign_to_weight(input logic label, input logic sign_bit);
    return label ^ sign_bit;
  endfunction

endpackage

// File: rtl/perceptron_trainer_if.sv
// Handshake and weight-load bundle between the trainer, its upstream sample
// source and the perceptron it drives.
interface perceptron_trainer_if #(
  parameter int WIDTH = 8
);
  logic                    s_val_i;
  logic                    s_rdy_o;
  logic signed [WIDTH-1:0] s_X0_i;
  logic signed [WIDTH-1:0] s_X1_i;
  logic                    s_label_i;

  logic                    p_val_o;
  logic                    p_rdy_i;
  logic signed [WIDTH-1:0] X0_o;
  logic signed [WIDTH-1:0] X1_o;
  logic                    p_val_i;
  logic                    p_rdy_o;
  logic                    Y_i;

  logic [1:0]              W1W0b_en_o;
  logic                    b_o;
  logic                    W0_o;
  logic                    W1_o;

  modport master (
    input  s_val_i, s_X0_i, s_X1_i, s_label_i, p_rdy_i, p_val_i, Y_i,
    output s_rdy_o, p_val_o, X0_o, X1_o, p_rdy_o, W1W0b_en_o, b_o, W0_o, W1_o
  );

  modport slave (
    output s_val_i, s_X0_i, s_X1_i, s_label_i, p_rdy_i, p_val_i, Y_i,
    input  s_rdy_o, p_val_o, X0_o, X1_o, p_rdy_o, W1W0b_en_o, b_o, W0_o, W1_o
  );
endinterface

// File: rtl/perceptron_sat_cnt.sv
// Saturating up-counter with a synchronous clear that beats an increment.
module perceptron_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/perceptron_trainer.sv
// Online training master: feeds labelled samples to the perceptron one at a
// time and rewrites its weights through the serial load port on a miss.
module perceptron_trainer
  import perceptron_pkg::*;
#(
  parameter int         WIDTH      = 8,
  parameter int         CNT_W      = 16,
  parameter logic [2:0] INIT_W1W0B = 3'b111
) (
  input  logic                 clk,
  input  logic                 reset,
  perceptron_trainer_if.master bus,
  input  logic                 train_en_i,
  input  logic                 clr_i,
  output logic [CNT_W-1:0]     err_cnt_o,
  output logic [CNT_W-1:0]     smp_cnt_o
);

  state_t                  r_state;
  state_t                  w_next;
  logic signed [WIDTH-1:0] r_x0;
  logic signed [WIDTH-1:0] r_x1;
  logic                    r_label;
  logic                    r_b;
  logic                    r_w0;
  logic                    r_w1;

  logic [1:0] w_en;
  logic       w_s_rdy;
  logic       w_p_val;
  logic       w_p_rdy;
  logic       w_y_hs;
  logic       w_miss;

  assign w_y_hs = (r_state == ST_WAIT) && bus.p_val_i;
  assign w_miss = (bus.Y_i != r_label);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_INIT_B;
      r_x0    <= '0;
      r_x1    <= '0;
      r_label <= 1'b0;
      r_w1    <= INIT_W1W0B[2];
      r_w0    <= INIT_W1W0B[1];
      r_b     <= INIT_W1W0B[0];
    end else begin
      r_state <= w_next;
      if ((r_state == ST_IDLE) && bus.s_val_i) begin
        r_x0    <= bus.s_X0_i;
        r_x1    <= bus.s_X1_i;
        r_label <= bus.s_label_i;
      end
      // The whole new shadow is committed at the handshake; UPD_* only streams it out.
      if (w_y_hs && w_miss && train_en_i) begin
        r_b  <= r_label;
        r_w0 <= sign_to_weight(r_label, r_x0[WIDTH-1]);
        r_w1 <= sign_to_weight(r_label, r_x1[WIDTH-1]);
      end
    end
  end

  always_comb begin
    w_next  = r_state;
    w_en    = EN_NONE;
    w_s_rdy = 1'b0;
    w_p_val = 1'b0;
    w_p_rdy = 1'b0;
    case (r_state)
      ST_INIT_B:  begin w_en = EN_B;  w_next = ST_INIT_W0; end
      ST_INIT_W0: begin w_en = EN_W0; w_next = ST_INIT_W1; end
      ST_INIT_W1: begin w_en = EN_W1; w_next = ST_IDLE;    end
      ST_IDLE: begin
        w_s_rdy = 1'b1;
        if (bus.s_val_i) w_next = ST_SEND;
      end
      ST_SEND: begin
        w_p_val = 1'b1;
        if (bus.p_rdy_i) w_next = ST_WAIT;
      end
      ST_WAIT: begin
        w_p_rdy = 1'b1;
        if (bus.p_val_i) w_next = (w_miss && train_en_i) ? ST_UPD_B : ST_IDLE;
      end
      ST_UPD_B:  begin w_en = EN_B;  w_next = ST_UPD_W0; end
      ST_UPD_W0: begin w_en = EN_W0; w_next = ST_UPD_W1; end
      ST_UPD_W1: begin w_en = EN_W1; w_next = ST_IDLE;   end
      default:   w_next = ST_INIT_B;
    endcase
    // Keep the perceptron and upstream quiet while reset is held.
    if (reset) begin
      w_en    = EN_NONE;
      w_s_rdy = 1'b0;
      w_p_val = 1'b0;
      w_p_rdy = 1'b0;
    end
  end

  assign bus.s_rdy_o    = w_s_rdy;
  assign bus.p_val_o    = w_p_val;
  assign bus.p_rdy_o    = w_p_rdy;
  assign bus.X0_o       = r_x0;
  assign bus.X1_o       = r_x1;
  assign bus.W1W0b_en_o = w_en;
  assign bus.b_o        = r_b;
  assign bus.W0_o       = r_w0;
  assign bus.W1_o       = r_w1;

  perceptron_sat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_y_hs && w_miss),
    .i_clr (clr_i),
    .o_cnt (err_cnt_o)
  );

  perceptron_sat_cnt #(.CNT_W(CNT_W)) u_smp_cnt (
    .clk   (clk),
    .reset (reset),
    .i_inc (w_y_hs),
    .i_clr (clr_i),
    .o_cnt (smp_cnt_o)
  );

endmodule

// File: tb/tb_perceptron_trainer.sv
// Directed bench for perceptron_trainer; narrow counters keep saturation reachable.
module tb_perceptron_trainer;
  import perceptron_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             train_en_i;
  logic             clr_i;
  logic [CNT_W-1:0] err_cnt_o;
  logic [CNT_W-1:0] smp_cnt_o;

  int compared;
  int mismatched;

  logic                    obsPval;
  logic                    obsSrdy;
  logic signed [WIDTH-1:0] obsX0;
  logic signed [WIDTH-1:0] obsX1;

  perceptron_trainer_if #(.WIDTH(WIDTH)) bus ();

  perceptron_trainer #(
    .WIDTH      (WIDTH),
    .CNT_W      (CNT_W),
    .INIT_W1W0B (3'b111)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .train_en_i (train_en_i),
    .clr_i      (clr_i),
    .err_cnt_o  (err_cnt_o),
    .smp_cnt_o  (smp_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Runs one sample from IDLE through the Y handshake; returns 1ns after that edge.
  task automatic send_sample(input logic signed [WIDTH-1:0] x0, input logic signed [WIDTH-1:0] x1,
                             input logic lbl, input logic y, input logic te, input logic clr);
    bus.s_val_i = 1'b1; bus.s_X0_i = x0; bus.s_X1_i = x1; bus.s_label_i = lbl;
    @(posedge clk); #1;
    bus.s_val_i = 1'b0; bus.s_X0_i = '0; bus.s_X1_i = '0; bus.s_label_i = 1'b0;
    obsPval = bus.p_val_o; obsSrdy = bus.s_rdy_o; obsX0 = bus.X0_o; obsX1 = bus.X1_o;
    bus.p_rdy_i = 1'b1;
    @(posedge clk); #1;
    bus.p_rdy_i = 1'b0;
    bus.p_val_i = 1'b1; bus.Y_i = y; train_en_i = te; clr_i = clr;
    @(posedge clk); #1;
    bus.p_val_i = 1'b0; bus.Y_i = 1'b0; clr_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; train_en_i = 1'b0; clr_i = 1'b0;
    bus.s_val_i = 1'b0; bus.s_X0_i = '0; bus.s_X1_i = '0; bus.s_label_i = 1'b0;
    bus.p_rdy_i = 1'b0; bus.p_val_i = 1'b0; bus.Y_i = 1'b0;
    repeat (3) @(posedge clk); #1;
    compared++;
    if ({bus.s_rdy_o, bus.p_val_o, bus.p_rdy_o, bus.W1W0b_en_o} !== 5'b00000) begin
      mismatched++; $display("[TB] FAIL rst_ctrl: got %b want 00000", {bus.s_rdy_o, bus.p_val_o, bus.p_rdy_o, bus.W1W0b_en_o});
    end
    compared++;
    if ({bus.X0_o, bus.X1_o, err_cnt_o, smp_cnt_o} !== 24'h0) begin
      mismatched++; $display("[TB] FAIL rst_data: got %h want 000000", {bus.X0_o, bus.X1_o, err_cnt_o, smp_cnt_o});
    end
    reset = 1'b0; #1;
    compared++;
    if ({bus.s_rdy_o, bus.W1W0b_en_o, bus.b_o} !== 4'b0011) begin
      mismatched++; $display("[TB] FAIL init_b: got %b want 0011", {bus.s_rdy_o, bus.W1W0b_en_o, bus.b_o});
    end
    @(posedge clk); #1;
    compared++;
    if ({bus.s_rdy_o, bus.W1W0b_en_o, bus.W0_o} !== 4'b0101) begin
      mismatched++; $display("[TB] FAIL init_w0: got %b want 0101", {bus.s_rdy_o, bus.W1W0b_en_o, bus.W0_o});
    end
    @(posedge clk); #1;
    compared++;
    if ({bus.s_rdy_o, bus.W1W0b_en_o, bus.W1_o} !== 4'b0111) begin
      mismatched++; $display("[TB] FAIL init_w1: got %b want 0111", {bus.s_rdy_o, bus.W1W0b_en_o, bus.W1_o});
    end
    @(posedge clk); #1;
    compared++;
    if ({bus.s_rdy_o, bus.W1W0b_en_o} !== 3'b100) begin
      mismatched++; $display("[TB] FAIL init_idle: got %b want 100", {bus.s_rdy_o, bus.W1W0b_en_o});
    end
  endtask

  task automatic test_correct();
    send_sample(8'sd5, -8'sd3, 1'b1, 1'b1, 1'b1, 1'b0);
    compared++;
    if ({obsPval, obsSrdy, obsX0, obsX1} !== {1'b1, 1'b0, 8'h05, 8'hFD}) begin
      mismatched++; $display("[TB] FAIL corr_send: got %h want %h", {obsPval, obsSrdy, obsX0, obsX1}, {1'b1, 1'b0, 8'h05, 8'hFD});
    end
    compared++;
    if ({bus.s_rdy_o, bus.W1W0b_en_o, err_cnt_o, smp_cnt_o} !== {1'b1, 2'b00, 4'd0, 4'd1}) begin
      mismatched++; $display("[TB] FAIL corr_done: got %h want %h", {bus.s_rdy_o, bus.W1W0b_en_o, err_cnt_o, smp_cnt_o}, {1'b1, 2'b00, 4'd0, 4'd1});
    end
  endtask

  task automatic test_train_update();
    send_sample(8'sd5, -8'sd3, 1'b1, 1'b0, 1'b1, 1'b0);
    compared++;
    if ({bus.s_rdy_o, bus.W1W0b_en_o, bus.b_o} !== 4'b0011) begin
      mismatched++; $display("[TB] FAIL upd1_b: got %b want 0011", {bus.s_rdy_o, bus.W1W0b_en_o, bus.b_o});
    end
    train_en_i = 1'b0;
    @(posedge clk); #1;
    compared++;
    if ({bus.W1W0b_en_o, bus.W0_o} !== 3'b101) begin
      mismatched++; $display("[TB] FAIL upd1_w0: got %b want 101", {bus.W1W0b_en_o, bus.W0_o});
    end
    @(posedge clk); #1;
    compared++;
    if ({bus.W1W0b_en_o, bus.W1_o} !== 3'b110) begin
      mismatched++; $display("[TB] FAIL upd1_w1: got %b want 110", {bus.W1W0b_en_o, bus.W1_o});
    end
    @(posedge clk); #1;
    compared++;
    if ({bus.s_rdy_o, bus.W1W0b_en_o, err_cnt_o, smp_cnt_o} !== {1'b1, 2'b00, 4'd1, 4'd2}) begin
      mismatched++; $display("[TB] FAIL upd1_done: got %h want %h", {bus.s_rdy_o, bus.W1W0b_en_o, err_cnt_o, smp_cnt_o}, {1'b1, 2'b00, 4'd1, 4'd2});
    end
  endtask

  task automatic test_inference_then_train();
    send_sample(-8'sd7, 8'sd0, 1'b0, 1'b1, 1'b0, 1'b0);
    compared++;
    if ({bus.s_rdy_o, bus.W1W0b_en_o, bus.b_o, bus.W0_o, bus.W1_o} !== 6'b100110) begin
      mismatched++; $display("[TB] FAIL inf_noupd: got %b want 100110", {bus.s_rdy_o, bus.W1W0b_en_o, bus.b_o, bus.W0_o, bus.W1_o});
    end
    compared++;
    if ({err_cnt_o, smp_cnt_o} !== {4'd2, 4'd3}) begin
      mismatched++; $display("[TB] FAIL inf_cnt: got %h want 23", {err_cnt_o, smp_cnt_o});
    end
    send_sample(-8'sd7, 8'sd0, 1'b0, 1'b1, 1'b1, 1'b0);
    compared++;
    if ({bus.W1W0b_en_o, bus.b_o} !== 3'b010) begin
      mismatched++; $display("[TB] FAIL upd2_b: got %b want 010", {bus.W1W0b_en_o, bus.b_o});
    end
    @(posedge clk); #1;
    compared++;
    if ({bus.W1W0b_en_o, bus.W0_o} !== 3'b101) begin
      mismatched++; $display("[TB] FAIL upd2_w0: got %b want 101", {bus.W1W0b_en_o, bus.W0_o});
    end
    @(posedge clk); #1;
    compared++;
    if ({bus.W1W0b_en_o, bus.W1_o} !== 3'b110) begin
      mismatched++; $display("[TB] FAIL upd2_w1: got %b want 110", {bus.W1W0b_en_o, bus.W1_o});
    end
    @(posedge clk); #1;
    compared++;
    if ({bus.s_rdy_o, err_cnt_o, smp_cnt_o} !== {1'b1, 4'd3, 4'd4}) begin
      mismatched++; $display("[TB] FAIL upd2_done: got %h want %h", {bus.s_rdy_o, err_cnt_o, smp_cnt_o}, {1'b1, 4'd3, 4'd4});
    end
  endtask

  task automatic test_back_pressure();
    bus.s_val_i = 1'b1; bus.s_X0_i = 8'sd20; bus.s_X1_i = -8'sd40; bus.s_label_i = 1'b1;
    @(posedge clk); #1;
    bus.s_X0_i = 8'sd99; bus.s_X1_i = -8'sd99;
    bus.p_val_i = 1'b1; bus.Y_i = 1'b0; train_en_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      compared++;
      if ({bus.p_val_o, bus.s_rdy_o, bus.p_rdy_o, bus.X0_o, bus.X1_o} !== {3'b100, 8'd20, 8'hD8}) begin
        mismatched++; $display("[TB] FAIL bp_hold%0d: got %h want %h", i, {bus.p_val_o, bus.s_rdy_o, bus.p_rdy_o, bus.X0_o, bus.X1_o}, {3'b100, 8'd20, 8'hD8});
      end
      @(posedge clk); #1;
    end
    compared++;
    if ({bus.p_val_o, err_cnt_o, smp_cnt_o} !== {1'b1, 4'd3, 4'd4}) begin
      mismatched++; $display("[TB] FAIL bp_ignore_pval: got %h want %h", {bus.p_val_o, err_cnt_o, smp_cnt_o}, {1'b1, 4'd3, 4'd4});
    end
    bus.s_val_i = 1'b0; bus.p_val_i = 1'b0; bus.p_rdy_i = 1'b1;
    @(posedge clk); #1;
    bus.p_rdy_i = 1'b0;
    compared++;
    if ({bus.p_val_o, bus.p_rdy_o, bus.s_rdy_o} !== 3'b010) begin
      mismatched++; $display("[TB] FAIL bp_wait: got %b want 010", {bus.p_val_o, bus.p_rdy_o, bus.s_rdy_o});
    end
    bus.p_val_i = 1'b1; bus.Y_i = 1'b1;
    @(posedge clk); #1;
    bus.p_val_i = 1'b0; bus.Y_i = 1'b0;
    compared++;
    if ({bus.s_rdy_o, bus.W1W0b_en_o, err_cnt_o, smp_cnt_o} !== {1'b1, 2'b00, 4'd3, 4'd5}) begin
      mismatched++; $display("[TB] FAIL bp_done: got %h want %h", {bus.s_rdy_o, bus.W1W0b_en_o, err_cnt_o, smp_cnt_o}, {1'b1, 2'b00, 4'd3, 4'd5});
    end
  endtask

  task automatic test_saturation();
    clr_i = 1'b1;
    @(posedge clk); #1;
    clr_i = 1'b0;
    compared++;
    if ({err_cnt_o, smp_cnt_o} !== 8'h00) begin
      mismatched++; $display("[TB] FAIL clr_only: got %h want 00", {err_cnt_o, smp_cnt_o});
    end
    for (int i = 0; i < 15; i++) send_sample(8'sd1, 8'sd1, 1'b1, 1'b0, 1'b0, 1'b0);
    compared++;
    if ({err_cnt_o, smp_cnt_o} !== 8'hFF) begin
      mismatched++; $display("[TB] FAIL sat_reach: got %h want ff", {err_cnt_o, smp_cnt_o});
    end
    send_sample(8'sd1, 8'sd1, 1'b1, 1'b0, 1'b0, 1'b0);
    compared++;
    if ({err_cnt_o, smp_cnt_o} !== 8'hFF) begin
      mismatched++; $display("[TB] FAIL sat_hold: got %h want ff", {err_cnt_o, smp_cnt_o});
    end
  endtask

  task automatic test_clear_with_error();
    send_sample(8'sd2, 8'sd2, 1'b1, 1'b0, 1'b0, 1'b1);
    compared++;
    if ({err_cnt_o, smp_cnt_o} !== 8'h00) begin
      mismatched++; $display("[TB] FAIL clr_wins: got %h want 00", {err_cnt_o, smp_cnt_o});
    end
    send_sample(8'sd2, 8'sd2, 1'b1, 1'b0, 1'b0, 1'b0);
    compared++;
    if ({err_cnt_o, smp_cnt_o} !== 8'h11) begin
      mismatched++; $display("[TB] FAIL clr_resume: got %h want 11", {err_cnt_o, smp_cnt_o});
    end
  endtask

  task automatic test_reset_mid_update();
    send_sample(8'sd3, -8'sd2, 1'b0, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    compared++;
    if ({bus.W1W0b_en_o, bus.b_o, bus.W0_o, bus.W1_o} !== 5'b10001) begin
      mismatched++; $display("[TB] FAIL rmu_inupd: got %b want 10001", {bus.W1W0b_en_o, bus.b_o, bus.W0_o, bus.W1_o});
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; #1;
    compared++;
    if ({bus.W1W0b_en_o, bus.b_o, bus.W0_o, bus.W1_o, err_cnt_o, smp_cnt_o} !== {5'b01111, 8'h00}) begin
      mismatched++; $display("[TB] FAIL rmu_initb: got %h want %h", {bus.W1W0b_en_o, bus.b_o, bus.W0_o, bus.W1_o, err_cnt_o, smp_cnt_o}, {5'b01111, 8'h00});
    end
    @(posedge clk); #1;
    compared++;
    if ({bus.W1W0b_en_o, bus.W0_o} !== 3'b101) begin
      mismatched++; $display("[TB] FAIL rmu_initw0: got %b want 101", {bus.W1W0b_en_o, bus.W0_o});
    end
    @(posedge clk); #1;
    compared++;
    if ({bus.W1W0b_en_o, bus.W1_o} !== 3'b111) begin
      mismatched++; $display("[TB] FAIL rmu_initw1: got %b want 111", {bus.W1W0b_en_o, bus.W1_o});
    end
    @(posedge clk); #1;
    compared++;
    if ({bus.s_rdy_o, bus.W1W0b_en_o} !== 3'b100) begin
      mismatched++; $display("[TB] FAIL rmu_idle: got %b want 100", {bus.s_rdy_o, bus.W1W0b_en_o});
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_correct();
    test_train_update();
    test_inference_then_train();
    test_back_pressure();
    test_saturation();
    test_clear_with_error();
    test_reset_mid_update();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
